// File: rtl/pifo_pop_drainer.sv
// Pop-side master for the PIFO: drains a programmed number of entries
// and checks that returned priority tags come back in non-decreasing order.
module pifo_pop_drainer #(
    parameter int PTW     = 8,
    parameter int MTW     = 0,
    parameter int CNT_W   = 8,
    parameter int POP_LAT = 1,
    parameter int GAP     = 0
) (
    input  logic                 i_clk,
    input  logic                 i_arst_n,
    input  logic                 i_start,
    input  logic [CNT_W-1:0]     i_num,
    input  logic                 i_abort,
    output logic                 o_pop,
    input  logic [PTW+MTW-1:0]   i_pop_data,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [CNT_W-1:0]     o_pop_cnt,
    output logic [PTW+MTW-1:0]   o_last_data,
    output logic [CNT_W-1:0]     o_err_cnt,
    output logic                 o_order_err
);

    localparam int DW = PTW + MTW;
    localparam int LW = $clog2(POP_LAT + 1);
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_WAIT,
        S_GAP,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [LW-1:0]    lat_q, lat_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic             first_q, first_d;
    logic [CNT_W-1:0] pop_cnt_q, pop_cnt_d;
    logic [DW-1:0]    last_q, last_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             order_err_q, order_err_d;

    always_ff @(posedge i_clk) begin
        if (!i_arst_n) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            lat_q       <= '0;
            gap_q       <= '0;
            first_q     <= 1'b0;
            pop_cnt_q   <= '0;
            last_q      <= '0;
            err_cnt_q   <= '0;
            order_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            lat_q       <= lat_d;
            gap_q       <= gap_d;
            first_q     <= first_d;
            pop_cnt_q   <= pop_cnt_d;
            last_q      <= last_d;
            err_cnt_q   <= err_cnt_d;
            order_err_q <= order_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        lat_d       = lat_q;
        gap_d       = gap_q;
        first_d     = first_q;
        pop_cnt_d   = pop_cnt_q;
        last_d      = last_q;
        err_cnt_d   = err_cnt_q;
        order_err_d = order_err_q;

        // Abort beats any sample or transition; counters are left as-is.
        if (i_abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        rem_d       = i_num;
                        pop_cnt_d   = '0;
                        err_cnt_d   = '0;
                        order_err_d = 1'b0;
                        last_d      = '0;
                        first_d     = 1'b1;
                        state_d     = (i_num == '0) ? S_DONE : S_POP;
                    end
                end
                S_POP: begin
                    lat_d   = LW'(POP_LAT);
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    lat_d = lat_q - LW'(1);
                    if (lat_q == LW'(1)) begin
                        if (!first_q &&
                            i_pop_data[PTW-1:0] < last_q[PTW-1:0]) begin
                            if (err_cnt_q != '1) begin
                                err_cnt_d = err_cnt_q + CNT_W'(1);
                            end
                            order_err_d = 1'b1;
                        end
                        last_d    = i_pop_data;
                        pop_cnt_d = pop_cnt_q + CNT_W'(1);
                        rem_d     = rem_q - CNT_W'(1);
                        first_d   = 1'b0;
                        if (rem_q == CNT_W'(1)) begin
                            state_d = S_DONE;
                        end else if (GAP > 0) begin
                            gap_d   = GW'(GAP);
                            state_d = S_GAP;
                        end else begin
                            state_d = S_POP;
                        end
                    end
                end
                S_GAP: begin
                    gap_d = gap_q - GW'(1);
                    if (gap_q == GW'(1)) begin
                        state_d = S_POP;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign o_pop       = (state_q == S_POP);
    assign o_busy      = (state_q != S_IDLE);
    assign o_done      = (state_q == S_DONE);
    assign o_pop_cnt   = pop_cnt_q;
    assign o_last_data = last_q;
    assign o_err_cnt   = err_cnt_q;
    assign o_order_err = order_err_q;

endmodule

// File: tb/tb_pifo_pop_drainer.sv
// Scoreboard bench for pifo_pop_drainer: default-parameter instance under
// random and directed runs, plus a POP_LAT=2 / GAP=1 instance.
module tb_pifo_pop_drainer;

    localparam int DW  = 8;
    localparam int CW  = 8;
    localparam int LAT = 1;
    localparam int GP  = 0;
    localparam int P   = 1 + LAT + GP;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [CW-1:0] num = '0;
    logic [DW-1:0] pdata = '0;
    logic          o_pop, o_busy, o_done, o_order_err;
    logic [CW-1:0] o_pop_cnt, o_err_cnt;
    logic [DW-1:0] o_last_data;

    logic          start2 = 1'b0;
    logic          abort2 = 1'b0;
    logic [1:0]    num2 = '0;
    logic [7:0]    pdata2 = '0;
    logic          pop2, busy2, done2, oerr2;
    logic [1:0]    cnt2, err2;
    logic [7:0]    last2;

    always #5 clk = ~clk;

    pifo_pop_drainer #(
        .PTW(8), .MTW(0), .CNT_W(CW), .POP_LAT(LAT), .GAP(GP)
    ) dut (
        .i_clk(clk), .i_arst_n(rst_n), .i_start(start), .i_num(num),
        .i_abort(abort), .o_pop(o_pop), .i_pop_data(pdata),
        .o_busy(o_busy), .o_done(o_done), .o_pop_cnt(o_pop_cnt),
        .o_last_data(o_last_data), .o_err_cnt(o_err_cnt),
        .o_order_err(o_order_err)
    );

    pifo_pop_drainer #(
        .PTW(8), .MTW(0), .CNT_W(2), .POP_LAT(2), .GAP(1)
    ) dut2 (
        .i_clk(clk), .i_arst_n(rst_n), .i_start(start2), .i_num(num2),
        .i_abort(abort2), .o_pop(pop2), .i_pop_data(pdata2),
        .o_busy(busy2), .o_done(done2), .o_pop_cnt(cnt2),
        .o_last_data(last2), .o_err_cnt(err2), .o_order_err(oerr2)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     nm, $signed(act), $signed(exp), cyc);
        end
    endtask

    typedef struct {
        int            cyc;
        int            k;
        logic [DW-1:0] last;
        int            err;
    } samp_t;

    int            popq[$];
    samp_t         sampq[$];
    int            doneq[$];
    logic [DW-1:0] dq[$];
    int            dueq[$];
    logic [DW-1:0] dvq[$];
    logic [DW-1:0] vals[$];
    bit            mon_en = 1'b0;
    bit            prev_pop = 1'b0;
    samp_t         sx;

    // Monitor: compares DUT activity against the expectation queues.
    always @(negedge clk) begin
        if (mon_en) begin
            if (o_pop) begin
                chk("pop_spacing", 64'(prev_pop), 0);
                if (popq.size() == 0) chk("unexpected_pop", cyc, -1);
                else chk("pop_cycle", cyc, popq.pop_front());
                dueq.push_back(cyc + LAT);
                dvq.push_back(dq.size() != 0 ? dq.pop_front() : DW'($urandom));
            end
            if (sampq.size() != 0 && cyc == sampq[0].cyc + 1) begin
                sx = sampq.pop_front();
                chk("sample_cnt", o_pop_cnt, sx.k);
                chk("sample_last", o_last_data, sx.last);
                chk("sample_err_cnt", o_err_cnt, sx.err);
                chk("sample_order_err", 64'(o_order_err), 64'(sx.err > 0));
            end
            if (o_done) begin
                if (doneq.size() == 0) chk("unexpected_done", cyc, -1);
                else begin
                    chk("done_cycle", cyc, doneq.pop_front());
                    chk("done_busy", 64'(o_busy), 1);
                end
            end
        end
        prev_pop = o_pop;
    end

    // Responder: data is valid only in the cycle it is due, garbage otherwise.
    always @(posedge clk) begin
        #1;
        if (dueq.size() != 0 && dueq[0] == cyc) begin
            void'(dueq.pop_front());
            pdata = dvq.pop_front();
        end else begin
            pdata = DW'($urandom);
        end
    end

    logic [7:0] vals2 [3] = '{8'd3, 8'd2, 8'd1};
    int         pop2q[$];
    int         due2q[$];
    int         idx2 = 0;
    int         done2c = -1;

    always @(negedge clk) begin
        if (pop2) begin
            pop2q.push_back(cyc);
            due2q.push_back(cyc + 2);
        end
        if (done2) done2c = cyc;
    end

    always @(posedge clk) begin
        #1;
        if (due2q.size() != 0 && due2q[0] == cyc) begin
            void'(due2q.pop_front());
            pdata2 = (idx2 < 3) ? vals2[idx2] : 8'hff;
            idx2++;
        end else begin
            pdata2 = 8'($urandom);
        end
    end

    // One run on the default instance; off>0 aborts in cycle c+off.
    task automatic run(int off, bit ab_start, bit extra);
        int c, a, d, n, endc, errs, cnt, p, s;
        logic [DW-1:0] last;
        @(posedge clk);
        #1;
        c = cyc;
        n = vals.size();
        d = (n == 0) ? c + 1 : c + n * P - GP + 1;
        a = (off > 0) ? c + off : -1;
        errs = 0;
        cnt = 0;
        last = '0;
        for (int k = 1; k <= n; k++) begin
            p = c + 1 + (k - 1) * P;
            s = c + k * P - GP;
            if (a < 0 || p <= a) popq.push_back(p);
            if (a < 0 || s < a) begin
                if (k > 1) begin
                    if (vals[k-1] < vals[k-2] && errs < 255) errs++;
                end
                last = vals[k-1];
                cnt = k;
                sampq.push_back('{s, k, last, errs});
            end
            dq.push_back(vals[k-1]);
        end
        if (a < 0) doneq.push_back(d);
        start = 1'b1;
        num = CW'(n);
        abort = ab_start;
        endc = (a < 0) ? d : a;
        while (cyc < endc + 2) begin
            @(posedge clk);
            #1;
            start = extra && a < 0 && n > 0 && cyc == c + 2;
            num = CW'($urandom);
            abort = (cyc == a);
        end
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        chk("end_busy", 64'(o_busy), 0);
        chk("end_pop_cnt", o_pop_cnt, cnt);
        chk("end_last_data", o_last_data, last);
        chk("end_err_cnt", o_err_cnt, errs);
        chk("end_order_err", 64'(o_order_err), 64'(errs > 0));
        chk("pops_missing", popq.size(), 0);
        chk("samples_missing", sampq.size(), 0);
        chk("done_missing", doneq.size(), 0);
        popq.delete();
        sampq.delete();
        doneq.delete();
        dq.delete();
    endtask

    initial begin
        int n, off, c2, dcount;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pop", 64'(o_pop), 0);
        chk("rst_busy", 64'(o_busy), 0);
        chk("rst_done", 64'(o_done), 0);
        chk("rst_cnt", o_pop_cnt, 0);
        chk("rst_last", o_last_data, 0);
        chk("rst_err", o_err_cnt, 0);
        chk("rst_oerr", 64'(o_order_err), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset in the middle of a run.
        @(posedge clk);
        #1;
        start = 1'b1;
        num = 8'd4;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 64'(o_busy), 0);
        chk("midrst_cnt", o_pop_cnt, 0);
        chk("midrst_last", o_last_data, 0);
        dcount = 0;
        repeat (10) begin
            @(negedge clk);
            if (o_done || o_pop) dcount++;
        end
        chk("midrst_no_activity", dcount, 0);
        mon_en = 1'b1;

        vals = '{8'd3, 8'd5, 8'd5, 8'd9};
        run(0, 1'b0, 1'b0);
        vals = '{8'd10, 8'd4, 8'd12, 8'd2};
        run(0, 1'b0, 1'b0);
        vals.delete();
        run(0, 1'b0, 1'b0);
        vals = '{8'd7, 8'd1, 8'd200, 8'd200};
        run(0, 1'b0, 1'b1);
        vals = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
        run(4, 1'b0, 1'b0);
        vals = '{8'd9, 8'd8};
        run(0, 1'b0, 1'b0);
        vals = '{8'd4, 8'd4, 8'd3};
        run(0, 1'b1, 1'b0);

        for (int r = 0; r < 25; r++) begin
            n = $urandom_range(0, 8);
            vals.delete();
            for (int i = 0; i < n; i++) vals.push_back(DW'($urandom_range(0, 255)));
            off = 0;
            if (n > 0 && $urandom_range(0, 3) == 0)
                off = $urandom_range(1, n * P - GP);
            run(off, 1'b0, off == 0 && $urandom_range(0, 1) == 1);
        end
        mon_en = 1'b0;

        // POP_LAT=2, GAP=1 instance, data 3,2,1.
        @(posedge clk);
        #1;
        c2 = cyc;
        start2 = 1'b1;
        num2 = 2'd3;
        @(posedge clk);
        #1 start2 = 1'b0;
        repeat (16) @(posedge clk);
        @(negedge clk);
        chk("alt_pop_count", pop2q.size(), 3);
        for (int i = 0; i < 3; i++)
            chk("alt_pop_cycle", (i < pop2q.size()) ? pop2q[i] : -1, c2 + 1 + 4 * i);
        chk("alt_done_cycle", done2c, c2 + 12);
        chk("alt_err_cnt", err2, 2);
        chk("alt_pop_cnt", cnt2, 3);
        chk("alt_last", last2, 1);
        chk("alt_order_err", 64'(oerr2), 1);
        chk("alt_busy", 64'(busy2), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
